// File: rtl/tetris_pkg.sv
// Shared types and constants for the text overlay and its score converter.
package tetris_pkg;
    localparam int         CHAR_W       = 7;
    localparam int         GLYPH_W      = 8;
    localparam logic [6:0] SPACE_CODE   = 7'h20;
    localparam logic [6:0] DIGIT_BASE   = 7'h30;
    localparam int         COLS         = 16;
    localparam int         ROWS         = 4;
    localparam int         CELLS        = COLS * ROWS;
    localparam int         SCORE_DIGITS = 5;
    localparam int         BCD_W        = 4 * SCORE_DIGITS;

    typedef enum logic [1:0] {IDLE, CONVERT, WRITE} score_state_e;

    // One double-dabble iteration on {bcd[19:0], bin[15:0]}: add 3 to every
    // BCD nibble >= 5, then shift the whole register left by one.
    function automatic logic [35:0] dd_step(input logic [35:0] v);
        logic [35:0] t;
        t = v;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            if (t[16+4*d +: 4] >= 4'd5)
                t[16+4*d +: 4] = t[16+4*d +: 4] + 4'd3;
        end
        return {t[34:0], 1'b0};
    endfunction
endpackage

// File: rtl/bin2bcd16.sv
// 16-bit binary to 5-digit BCD, one shift-add-3 step per cycle (16 cycles).
module bin2bcd16 import tetris_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);
    logic [35:0] sr;
    logic [3:0]  cnt;

    // The first step is folded into the load, so 15 more steps follow and
    // done is high in the cycle right after the 16th step lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                sr  <= dd_step({20'd0, bin});
                cnt <= 4'd15;
            end else if (cnt != 4'd0) begin
                sr   <= dd_step(sr);
                cnt  <= cnt - 4'd1;
                done <= (cnt == 4'd1);
            end
        end
    end

    assign busy = (cnt != 4'd0);
    assign bcd  = sr[35:16];
endmodule

// File: rtl/text_overlay.sv
// 16x4 character text window overlay with a BCD score field writer.
module text_overlay import tetris_pkg::*; #(
    parameter int ORIGIN_X   = 480,
    parameter int ORIGIN_Y   = 32,
    parameter int SCORE_BASE = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         draw_x,
    input  logic [9:0]         draw_y,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic               de_in,
    input  logic               wr_en,
    input  logic [5:0]         wr_addr,
    input  logic [CHAR_W-1:0]  wr_char,
    input  logic               score_valid,
    input  logic [15:0]        score,
    output logic               score_ready,
    output logic [CHAR_W-1:0]  ascii_addr,
    output logic [2:0]         char_row,
    input  logic [GLYPH_W-1:0] rom_data,
    output logic               text_on,
    output logic               hs_out,
    output logic               vs_out,
    output logic               de_out
);
    localparam int         STAGES = 2;
    localparam logic [9:0] OX     = 10'(ORIGIN_X);
    localparam logic [9:0] OY     = 10'(ORIGIN_Y);
    localparam logic [5:0] SB     = 6'(SCORE_BASE);

    logic [CHAR_W-1:0] tbuf [CELLS];

    // Stage 0: window-relative coordinates and buffer index.
    logic [9:0] dx, dy;
    logic       in_win;
    logic [5:0] rd_idx;
    assign dx     = draw_x - OX;
    assign dy     = draw_y - OY;
    assign in_win = (draw_x >= OX) && (dx < 10'd128) && (draw_y >= OY) && (dy < 10'd32);
    assign rd_idx = {dy[4:3], dx[6:3]};

    logic [CHAR_W-1:0]          char_d1;
    logic [2:0]                 grow_d1, bit_d1;
    logic                       in_win_d1;
    logic [STAGES-1:0][2:0]     sync_pipe;

    // Stage 1 registers the character and glyph coordinates; stage 2 the pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_d1   <= '0;
            grow_d1   <= '0;
            bit_d1    <= '0;
            in_win_d1 <= 1'b0;
            text_on   <= 1'b0;
            sync_pipe <= '0;
        end else begin
            char_d1   <= tbuf[rd_idx];
            grow_d1   <= dy[2:0];
            bit_d1    <= dx[2:0];
            in_win_d1 <= in_win;
            // Space has no glyph in the ROM, so it is blanked explicitly.
            text_on   <= in_win_d1 && (char_d1 != SPACE_CODE) && rom_data[3'd7 - bit_d1];
            sync_pipe <= {sync_pipe[STAGES-2:0], {hs_in, vs_in, de_in}};
        end
    end

    assign ascii_addr               = char_d1;
    assign char_row                 = grow_d1;
    assign {hs_out, vs_out, de_out} = sync_pipe[STAGES-1];

    // Score FSM
    score_state_e      state, state_nx;
    logic [2:0]        widx, widx_nx;
    logic              lead, lead_nx;
    logic              fsm_we;
    logic [CHAR_W-1:0] fsm_char;
    logic [5:0]        fsm_addr;
    logic [3:0]        digit;
    logic              conv_start, conv_busy, conv_done;
    logic [BCD_W-1:0]  bcd;

    assign score_ready = (state == IDLE);
    assign conv_start  = score_valid && score_ready;
    assign fsm_addr    = SB + {3'b000, widx};

    bin2bcd16 u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (score),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Digit sequencing MSD first; leading zeros blank until the last digit.
    always_comb begin
        state_nx = state;
        widx_nx  = widx;
        lead_nx  = lead;
        fsm_we   = 1'b0;
        case (widx)
            3'd0:    digit = bcd[19:16];
            3'd1:    digit = bcd[15:12];
            3'd2:    digit = bcd[11:8];
            3'd3:    digit = bcd[7:4];
            default: digit = bcd[3:0];
        endcase
        fsm_char = (lead && digit == 4'd0 && widx != 3'd4) ? SPACE_CODE
                                                             : DIGIT_BASE + {3'b000, digit};
        case (state)
            IDLE: if (conv_start) state_nx = CONVERT;
            CONVERT: begin
                if (conv_done) begin
                    state_nx = WRITE;
                    widx_nx  = 3'd0;
                    lead_nx  = 1'b1;
                end else if (!conv_busy) begin
                    state_nx = IDLE;
                end
            end
            WRITE: begin
                fsm_we = 1'b1;
                // External write owns the port this cycle; retry the same digit.
                if (!wr_en) begin
                    if (digit != 4'd0) lead_nx = 1'b0;
                    if (widx == 3'd4) state_nx = IDLE;
                    else              widx_nx  = widx + 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            widx  <= '0;
            lead  <= 1'b0;
        end else begin
            state <= state_nx;
            widx  <= widx_nx;
            lead  <= lead_nx;
        end
    end

    // Text buffer write port: external writes win over the score writer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CELLS; i++) tbuf[i] <= SPACE_CODE;
        end else if (wr_en) begin
            tbuf[wr_addr] <= wr_char;
        end else if (fsm_we) begin
            tbuf[fsm_addr] <= fsm_char;
        end
    end
endmodule

// File: tb/tb_text_overlay.sv
// Self-checking bench for text_overlay: vector table, score sequences, random pixels.
module tb_text_overlay;
    logic       clk, rst_n;
    logic [9:0] draw_x, draw_y;
    logic       hs_in, vs_in, de_in;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [6:0] wr_char;
    logic       score_valid, score_ready;
    logic [15:0] score;
    logic [6:0] ascii_addr;
    logic [2:0] char_row;
    logic [7:0] rom_data;
    logic       text_on, hs_out, vs_out, de_out;

    logic       rom_force_en;
    logic [7:0] rom_force;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [6:0] mem [64];

    text_overlay dut (
        .clk(clk), .rst_n(rst_n), .draw_x(draw_x), .draw_y(draw_y),
        .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .score_valid(score_valid), .score(score), .score_ready(score_ready),
        .ascii_addr(ascii_addr), .char_row(char_row), .rom_data(rom_data),
        .text_on(text_on), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out)
    );

    // Stand-in glyph ROM: arbitrary but deterministic pattern per (char,row).
    function automatic logic [7:0] rom_fn(input logic [6:0] c, input logic [2:0] r);
        return 8'(({1'b0, c} * 8'd29) ^ ({5'd0, r} * 8'd83) ^ 8'h5A);
    endfunction

    assign rom_data = rom_force_en ? rom_force : rom_fn(ascii_addr, char_row);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected score field from decimal arithmetic.
    function automatic logic [4:0][6:0] exp_score(input int v);
        logic [4:0][6:0] e;
        bit lead;
        int d, p;
        lead = 1;
        p = 10000;
        for (int k = 0; k < 5; k++) begin
            d = (v / p) % 10;
            p = p / 10;
            if (lead && d == 0 && k < 4) e[k] = 7'h20;
            else begin
                lead = 0;
                e[k] = 7'(7'h30 + d);
            end
        end
        return e;
    endfunction

    task automatic read_cell(input int idx, output logic [6:0] c);
        draw_x = 10'(480 + (idx % 16) * 8);
        draw_y = 10'(32 + (idx / 16) * 8);
        step();
        c = ascii_addr;
    endtask

    task automatic write_cell(input int idx, input logic [6:0] c);
        wr_en = 1'b1; wr_addr = 6'(idx); wr_char = c;
        step();
        wr_en = 1'b0;
    endtask

    task automatic run_score(input int v, input int stall_at, input int exp_low, input string tag);
        int cnt;
        logic [6:0] got;
        logic [4:0][6:0] e;
        chk({tag, " ready before"}, 32'(score_ready), 32'd1);
        score = 16'(v); score_valid = 1'b1;
        step();
        score_valid = 1'b0;
        cnt = 0;
        while (!score_ready && cnt < 100) begin
            // A request while busy must be dropped.
            if (cnt == 3) begin score_valid = 1'b1; score = 16'd9999; end
            else score_valid = 1'b0;
            wr_en = (cnt == stall_at); wr_addr = 6'd12; wr_char = 7'h5A;
            cnt++;
            step();
        end
        wr_en = 1'b0; score_valid = 1'b0;
        chk({tag, " ready-low cycles"}, 32'(cnt), 32'(exp_low));
        e = exp_score(v);
        for (int k = 0; k < 5; k++) begin
            read_cell(11 + k, got);
            chk($sformatf("%s buf[%0d]", tag, 11 + k), 32'(got), 32'(e[k]));
        end
    endtask

    typedef struct {
        int         x, y;
        logic [7:0] rom;
        bit         chk_a;
        logic [6:0] a;
        logic [2:0] r;
        logic       t;
    } vec_t;

    typedef struct {
        bit         iw;
        logic [6:0] ch;
        logic [2:0] gr, bt, sy;
    } pix_t;

    initial begin
        vec_t vt[12];
        pix_t cur, prev;
        logic [6:0] got;
        int x, y;
        bit ew;
        logic [5:0] ea;
        logic [6:0] ec;

        rst_n = 1'b0; draw_x = '0; draw_y = '0; hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_char = '0; score_valid = 1'b0; score = '0;
        rom_force_en = 1'b0; rom_force = '0;

        // Reset state
        #3;
        chk("rst ready", 32'(score_ready), 32'd1);
        chk("rst ascii_addr", 32'(ascii_addr), 32'd0);
        chk("rst char_row", 32'(char_row), 32'd0);
        chk("rst text_on", 32'(text_on), 32'd0);
        step(); step();
        chk("rst hs/vs/de held", 32'({hs_out, vs_out, de_out}), 32'd0);
        rst_n = 1'b1;
        hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b0;
        #1;
        chk("post-rst ascii_addr", 32'(ascii_addr), 32'd0);
        chk("post-rst ready", 32'(score_ready), 32'd1);

        // Vector table
        write_cell(0, 7'h53);
        write_cell(15, 7'h41);
        vt[0]  = '{480, 32, 8'hFF, 1, 7'h53, 3'd0, 1'b1};
        vt[1]  = '{480, 32, 8'h7F, 1, 7'h53, 3'd0, 1'b0};
        vt[2]  = '{487, 32, 8'h01, 1, 7'h53, 3'd0, 1'b1};
        vt[3]  = '{487, 39, 8'hFE, 1, 7'h53, 3'd7, 1'b0};
        vt[4]  = '{479, 32, 8'hFF, 0, 7'h00, 3'd0, 1'b0};
        vt[5]  = '{608, 32, 8'hFF, 0, 7'h00, 3'd0, 1'b0};
        vt[6]  = '{607, 32, 8'h01, 1, 7'h41, 3'd0, 1'b1};
        vt[7]  = '{480, 40, 8'hFF, 1, 7'h20, 3'd0, 1'b0};
        vt[8]  = '{480, 31, 8'hFF, 0, 7'h00, 3'd0, 1'b0};
        vt[9]  = '{480, 64, 8'hFF, 0, 7'h00, 3'd0, 1'b0};
        vt[10] = '{483, 63, 8'hFF, 1, 7'h20, 3'd7, 1'b0};
        vt[11] = '{484, 35, 8'h08, 1, 7'h53, 3'd3, 1'b1};
        rom_force_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            draw_x = 10'(vt[i].x); draw_y = 10'(vt[i].y); rom_force = vt[i].rom;
            step();
            if (vt[i].chk_a) begin
                chk($sformatf("vec%0d ascii_addr", i), 32'(ascii_addr), 32'(vt[i].a));
                chk($sformatf("vec%0d char_row", i), 32'(char_row), 32'(vt[i].r));
            end
            step();
            chk($sformatf("vec%0d text_on", i), 32'(text_on), 32'(vt[i].t));
        end
        rom_force_en = 1'b0;

        // Score conversion and digit writing
        run_score(1234, -1, 21, "score1234");
        run_score(0, -1, 21, "score0");
        run_score(65535, -1, 21, "score65535");
        run_score(40321, 17, 22, "stall40321");

        // Reset in the middle of a conversion
        score = 16'd1234; score_valid = 1'b1;
        step();
        score_valid = 1'b0;
        repeat (5) step();
        chk("midconv ready low", 32'(score_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst ready", 32'(score_ready), 32'd1);
        chk("midrst text_on", 32'(text_on), 32'd0);
        chk("midrst ascii_addr", 32'(ascii_addr), 32'd0);
        step();
        rst_n = 1'b1;
        hs_in = 1'b1;
        step();
        hs_in = 1'b0;
        chk("hs delay 1", 32'(hs_out), 32'd0);
        step();
        chk("hs delay 2", 32'(hs_out), 32'd1);
        step();
        chk("hs delay 3", 32'(hs_out), 32'd0);
        repeat (25) step();
        chk("post-midrst ready", 32'(score_ready), 32'd1);
        for (int i = 0; i < 64; i++) begin
            read_cell(i, got);
            chk($sformatf("cleared buf[%0d]", i), 32'(got), 32'h20);
        end

        // Randomized pixels and writes against the reference model
        for (int i = 0; i < 64; i++) mem[i] = 7'h20;
        prev = '{0, 7'h00, 3'd0, 3'd0, 3'd0};
        for (int n = 0; n < 400; n++) begin
            x = int'($urandom_range(470, 620));
            y = int'($urandom_range(24, 72));
            ew = ($urandom_range(0, 3) == 0);
            ea = 6'($urandom_range(0, 63));
            ec = ($urandom_range(0, 4) == 0) ? 7'h20 : 7'($urandom_range(33, 126));
            cur.iw = (x >= 480) && (x < 608) && (y >= 32) && (y < 64);
            cur.ch = cur.iw ? mem[((y - 32) / 8) * 16 + (x - 480) / 8] : 7'h00;
            cur.gr = 3'((y - 32) % 8);
            cur.bt = 3'((x - 480) % 8);
            cur.sy = 3'($urandom_range(0, 7));
            draw_x = 10'(x); draw_y = 10'(y);
            {hs_in, vs_in, de_in} = cur.sy;
            wr_en = ew; wr_addr = ea; wr_char = ec;
            step();
            if (ew) mem[ea] = ec;
            if (cur.iw) begin
                chk($sformatf("rnd%0d ascii_addr", n), 32'(ascii_addr), 32'(cur.ch));
                chk($sformatf("rnd%0d char_row", n), 32'(char_row), 32'(cur.gr));
            end
            if (n > 0) begin
                chk($sformatf("rnd%0d syncs", n), 32'({hs_out, vs_out, de_out}), 32'(prev.sy));
                chk($sformatf("rnd%0d text_on", n), 32'(text_on),
                    32'(prev.iw && prev.ch != 7'h20 && rom_fn(prev.ch, prev.gr)[7 - prev.bt]));
            end
            prev = cur;
        end
        wr_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
